ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Byte-serial RAM arbiter: serialises instruction fetch, data load and data store
// onto one 8-bit synchronous RAM port, fixed priority store > load > fetch.
module ram_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  clear_in,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_done,
    output logic [31:0]           if_data,
    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [1:0]            ld_len,
    output logic                  ld_done,
    output logic [31:0]           ld_data,
    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [1:0]            st_len,
    input  logic [31:0]           st_data,
    output logic                  st_done,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    output logic [1:0]            grant
);
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        LOAD  = 2'b10,
        STORE = 2'b11
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            len;
    logic [31:0]           wdata;
    logic [31:0]           rbuf;
    logic                  mem_wr_q;

    logic [CNT_W-1:0]      cnt_inc;
    logic [CNT_W-1:0]      n_bytes;
    logic [ADDR_WIDTH-1:0] a_next;
    logic [1:0]            rd_idx;
    logic [31:0]           rd_final;
    logic [7:0]            wr_next;
    logic                  rd_last;
    logic                  wr_last;
    logic                  st_go;
    logic                  ld_go;
    logic                  if_go;

    // Datapath helpers; rd_final merges the byte arriving this cycle (1-cycle RAM latency)
    always_comb begin
        cnt_inc  = cnt + CNT_W'(1);
        n_bytes  = CNT_W'(len) + CNT_W'(1);
        a_next   = addr + ADDR_WIDTH'(cnt_inc);
        rd_idx   = 2'(cnt - CNT_W'(1));
        rd_final = rbuf;
        rd_final[{rd_idx, 3'b000} +: 8] = mem_din;
        wr_next  = wdata[{cnt_inc[1:0], 3'b000} +: 8];
        rd_last  = (cnt == n_bytes);
        wr_last  = (cnt[1:0] == len);
        // a requester whose done is showing sits out this arbitration round
        st_go    = st_req && !st_done;
        ld_go    = ld_req && !ld_done && !clear_in;
        if_go    = if_req && !if_done && !clear_in;
    end

    // Control FSM; bus outputs are registered for the cycle the counter reaches
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state    <= IDLE;
            cnt      <= '0;
            addr     <= '0;
            len      <= '0;
            wdata    <= '0;
            rbuf     <= '0;
            if_done  <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
            if_data  <= '0;
            ld_data  <= '0;
            mem_wr_q <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
        end else if (rdy_in) begin
            if_done  <= 1'b0;
            ld_done  <= 1'b0;
            st_done  <= 1'b0;
            mem_wr_q <= 1'b0;
            mem_a    <= '0;
            mem_dout <= '0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    rbuf <= '0;
                    if (st_go) begin
                        state    <= STORE;
                        addr     <= st_addr;
                        len      <= st_len;
                        wdata    <= st_data;
                        mem_wr_q <= 1'b1;
                        mem_a    <= st_addr;
                        mem_dout <= st_data[7:0];
                    end else if (ld_go) begin
                        state <= LOAD;
                        addr  <= ld_addr;
                        len   <= ld_len;
                        mem_a <= ld_addr;
                    end else if (if_go) begin
                        state <= FETCH;
                        addr  <= if_addr;
                        len   <= 2'd3;
                        mem_a <= if_addr;
                    end
                end
                FETCH, LOAD: begin
                    if (clear_in) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else begin
                        if (cnt != '0) begin
                            rbuf <= rd_final;
                        end
                        if (rd_last) begin
                            state <= IDLE;
                            cnt   <= '0;
                            if (state == FETCH) begin
                                if_done <= 1'b1;
                                if_data <= rd_final;
                            end else begin
                                ld_done <= 1'b1;
                                ld_data <= rd_final;
                            end
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc != n_bytes) begin
                                mem_a <= a_next;
                            end
                        end
                    end
                end
                STORE: begin
                    // committed stores ignore clear_in
                    if (wr_last) begin
                        state   <= IDLE;
                        cnt     <= '0;
                        st_done <= 1'b1;
                    end else begin
                        cnt      <= cnt_inc;
                        mem_wr_q <= 1'b1;
                        mem_a    <= a_next;
                        mem_dout <= wr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_wr = mem_wr_q & rdy_in;
    assign grant  = 2'(state);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: a table of single transfers plus hand-written
// sequences for arbitration order, done masking, flush, stall and reset.
module tb_ram_arbiter;
    localparam int unsigned AW = 32;
    localparam logic [1:0] G_IDLE = 2'b00;
    localparam logic [1:0] G_FE   = 2'b01;
    localparam logic [1:0] G_LD   = 2'b10;
    localparam logic [1:0] G_ST   = 2'b11;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          cycles;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rdy = 1'b0;
    logic          clear = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_done;
    logic [31:0]   if_data;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [1:0]    ld_len = '0;
    logic          ld_done;
    logic [31:0]   ld_data;
    logic          st_req = 1'b0;
    logic [AW-1:0] st_addr = '0;
    logic [1:0]    st_len = '0;
    logic [31:0]   st_data = '0;
    logic          st_done;
    logic [7:0]    mem_din = '0;
    logic [7:0]    mem_dout;
    logic [AW-1:0] mem_a;
    logic          mem_wr;
    logic [1:0]    grant;

    int total = 0;
    int bad = 0;
    vec_t vecs [8];
    logic [7:0] ram [bit [31:0]];

    ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clear),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_len(ld_len), .ld_done(ld_done), .ld_data(ld_data),
        .st_req(st_req), .st_addr(st_addr), .st_len(st_len), .st_data(st_data), .st_done(st_done),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr), .grant(grant)
    );

    always #5 clk = ~clk;

    // Synchronous byte RAM, one cycle read latency, sharing the global enable
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a] = mem_dout;
            mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
        end
    end

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic done_of(input logic [1:0] k);
        case (k)
            G_FE:    return if_done;
            G_LD:    return ld_done;
            default: return st_done;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_req(input logic [1:0] k, input logic [31:0] a,
                             input logic [1:0] l, input logic [31:0] d);
        case (k)
            G_FE: begin if_req = 1'b1; if_addr = a; end
            G_LD: begin ld_req = 1'b1; ld_addr = a; ld_len = l; end
            default: begin st_req = 1'b1; st_addr = a; st_len = l; st_data = d; end
        endcase
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (grant != G_IDLE && c < 20) begin
            step();
            c++;
        end
        check(name, 32'(grant), 32'(G_IDLE));
        step();
    endtask

    task automatic run_txn(input vec_t v);
        int c;
        int n;
        n = (v.kind == G_FE) ? 4 : int'(v.len) + 1;
        start_req(v.kind, v.addr, v.len, v.wdata);
        step();
        if_req = 1'b0; ld_req = 1'b0; st_req = 1'b0;
        if_addr = '1; ld_addr = '1; st_addr = '1; st_data = '1; ld_len = '0; st_len = '0;
        c = 0;
        while (grant == v.kind && c < 12) begin
            if (v.kind == G_ST) begin
                check("st_wr", 32'(mem_wr), 32'd1);
                check("st_a", mem_a, v.addr + 32'(c));
                check("st_dout", 32'(mem_dout), 32'(8'(v.wdata >> (8 * c))));
            end else begin
                check("rd_wr", 32'(mem_wr), 32'd0);
                check("rd_a", mem_a, (c < n) ? v.addr + 32'(c) : 32'h0);
            end
            c++;
            step();
        end
        check("cycles", 32'(c), 32'(v.cycles));
        check("grant_idle", 32'(grant), 32'(G_IDLE));
        check("done", 32'(done_of(v.kind)), 32'd1);
        if (v.kind == G_FE) check("if_data", if_data, v.exp);
        else if (v.kind == G_LD) check("ld_data", ld_data, v.exp);
        else begin
            for (int b = 0; b <= int'(v.len); b++)
                check("st_ram", 32'(ram_rd(v.addr + 32'(b))), 32'(8'(v.wdata >> (8 * b))));
        end
        step();
        check("done_pulse", 32'(done_of(v.kind)), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] order [3];
        int k;
        int c;
        logic [1:0] last;

        ram[32'h100] = 8'h13; ram[32'h101] = 8'h05; ram[32'h102] = 8'h00; ram[32'h103] = 8'h00;
        ram[32'h1FFFF] = 8'h34; ram[32'h20000] = 8'h12;
        ram[32'h300] = 8'hA5; ram[32'h301] = 8'h5A;
        ram[32'h400] = 8'h11; ram[32'h401] = 8'h22; ram[32'h402] = 8'h33; ram[32'h403] = 8'h44;
        ram[32'h502] = 8'h77; ram[32'h503] = 8'h66;
        ram[32'h600] = 8'h01; ram[32'h601] = 8'h02; ram[32'h602] = 8'h03; ram[32'h603] = 8'h04;
        ram[32'h700] = 8'hAA; ram[32'h701] = 8'hBB; ram[32'h702] = 8'hCC; ram[32'h703] = 8'hDD;
        ram[32'h900] = 8'hF1; ram[32'h901] = 8'hF2; ram[32'h902] = 8'hF3; ram[32'h903] = 8'hF4;

        vecs[0] = '{G_FE, 32'h0000_0100, 2'd3, 32'h0, 32'h0000_0513, 5};
        vecs[1] = '{G_LD, 32'h0001_FFFF, 2'd1, 32'h0, 32'h0000_1234, 3};
        vecs[2] = '{G_LD, 32'h0000_0300, 2'd0, 32'h0, 32'h0000_00A5, 2};
        vecs[3] = '{G_LD, 32'h0000_0400, 2'd2, 32'h0, 32'h0033_2211, 4};
        vecs[4] = '{G_ST, 32'h0000_0500, 2'd1, 32'hCAFE_BABE, 32'h0, 2};
        vecs[5] = '{G_LD, 32'h0000_0500, 2'd3, 32'h0, 32'h6677_BABE, 5};
        vecs[6] = '{G_ST, 32'hFFFF_FFFE, 2'd3, 32'h4433_2211, 32'h0, 4};
        vecs[7] = '{G_FE, 32'hFFFF_FFFE, 2'd3, 32'h0, 32'h4433_2211, 5};

        // reset values, with the enable low
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_if_done", 32'(if_done), 32'd0);
        check("rst_ld_done", 32'(ld_done), 32'd0);
        check("rst_st_done", 32'(st_done), 32'd0);
        check("rst_if_data", if_data, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_a", mem_a, 32'd0);
        check("rst_mem_dout", 32'(mem_dout), 32'd0);
        rdy = 1'b1;
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);

        // held fetch request is masked in its done cycle, then re-granted
        start_req(G_FE, 32'h100, 2'd3, 32'h0);
        step();
        c = 0;
        while (grant == G_FE && c < 12) begin step(); c++; end
        check("mask_done", 32'(if_done), 32'd1);
        check("mask_data", if_data, 32'h0000_0513);
        step();
        check("mask_grant", 32'(grant), 32'(G_IDLE));
        check("mask_done_low", 32'(if_done), 32'd0);
        step();
        check("mask_regrant", 32'(grant), 32'(G_FE));
        if_req = 1'b0;
        wait_idle("mask_idle");

        // simultaneous store, load and fetch
        start_req(G_ST, 32'h200, 2'd3, 32'hDEAD_BEEF);
        start_req(G_LD, 32'h600, 2'd3, 32'h0);
        start_req(G_FE, 32'h700, 2'd3, 32'h0);
        k = 0;
        last = G_IDLE;
        repeat (40) begin
            step();
            if (grant != G_IDLE && grant != last && k < 3) begin
                order[k] = grant;
                k++;
            end
            last = grant;
            if (grant == G_ST) st_req = 1'b0;
            if (grant == G_LD) ld_req = 1'b0;
            if (grant == G_FE) if_req = 1'b0;
        end
        check("arb_count", 32'(k), 32'd3);
        check("arb_first", 32'(order[0]), 32'(G_ST));
        check("arb_second", 32'(order[1]), 32'(G_LD));
        check("arb_third", 32'(order[2]), 32'(G_FE));
        check("arb_ram", {ram_rd(32'h203), ram_rd(32'h202), ram_rd(32'h201), ram_rd(32'h200)},
              32'hDEAD_BEEF);
        check("arb_ld_data", ld_data, 32'h0403_0201);
        check("arb_if_data", if_data, 32'hDDCC_BBAA);

        // flush a fetch at counter 2
        start_req(G_FE, 32'h900, 2'd3, 32'h0);
        step();
        if_req = 1'b0;
        step();
        step();
        check("fl_grant", 32'(grant), 32'(G_FE));
        clear = 1'b1;
        step();
        check("fl_idle", 32'(grant), 32'(G_IDLE));
        check("fl_no_done", 32'(if_done), 32'd0);
        clear = 1'b0;
        step();
        check("fl_no_done2", 32'(if_done), 32'd0);
        check("fl_if_data", if_data, 32'hDDCC_BBAA);

        // clear held through a store
        start_req(G_ST, 32'h800, 2'd3, 32'h0A0B_0C0D);
        step();
        st_req = 1'b0;
        clear = 1'b1;
        c = 0;
        while (grant == G_ST && c < 12) begin step(); c++; end
        check("flst_cycles", 32'(c), 32'd4);
        check("flst_done", 32'(st_done), 32'd1);
        check("flst_ram", {ram_rd(32'h803), ram_rd(32'h802), ram_rd(32'h801), ram_rd(32'h800)},
              32'h0A0B_0C0D);
        step();

        // clear in IDLE blocks load and fetch, then load wins over fetch
        if_req = 1'b1; if_addr = 32'h100;
        ld_req = 1'b1; ld_addr = 32'h400; ld_len = 2'd2;
        step();
        check("clr_block", 32'(grant), 32'(G_IDLE));
        clear = 1'b0;
        step();
        check("clr_ld_first", 32'(grant), 32'(G_LD));
        if_req = 1'b0; ld_req = 1'b0;
        wait_idle("clr_ld_idle");
        check("clr_ld_data", ld_data, 32'h0033_2211);
        clear = 1'b1;
        start_req(G_ST, 32'h810, 2'd0, 32'h0000_005E);
        step();
        check("clr_st_grant", 32'(grant), 32'(G_ST));
        st_req = 1'b0;
        clear = 1'b0;
        wait_idle("clr_st_idle");
        check("clr_st_ram", 32'(ram_rd(32'h810)), 32'h5E);

        // stall mid-load
        start_req(G_LD, 32'h900, 2'd3, 32'h0);
        step();
        ld_req = 1'b0;
        step();
        rdy = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check("stall_a", mem_a, 32'h901);
            check("stall_wr", 32'(mem_wr), 32'd0);
            check("stall_grant", 32'(grant), 32'(G_LD));
        end
        rdy = 1'b1;
        step();
        c = 0;
        check("resume_a", mem_a, 32'h902);
        while (grant == G_LD && c < 12) begin step(); c++; end
        check("resume_cycles", 32'(c), 32'd3);
        check("resume_done", 32'(ld_done), 32'd1);
        check("resume_data", ld_data, 32'hF4F3_F2F1);
        step();

        // stall mid-store gates the write strobe
        start_req(G_ST, 32'hB00, 2'd1, 32'h0000_1234);
        step();
        st_req = 1'b0;
        check("sst_wr_on", 32'(mem_wr), 32'd1);
        rdy = 1'b0;
        #1;
        check("sst_wr_gated", 32'(mem_wr), 32'd0);
        step();
        check("sst_wr_held", 32'(mem_wr), 32'd0);
        check("sst_a", mem_a, 32'hB00);
        rdy = 1'b1;
        wait_idle("sst_idle");
        check("sst_ram", {16'h0, ram_rd(32'hB01), ram_rd(32'hB00)}, 32'h0000_1234);

        // reset at byte 1 of a 4-byte store
        start_req(G_ST, 32'hA00, 2'd3, 32'h5566_7788);
        step();
        st_req = 1'b0;
        step();
        check("rs_a_before", mem_a, 32'hA01);
        rst = 1'b1;
        #1;
        check("rs_grant", 32'(grant), 32'(G_IDLE));
        check("rs_wr", 32'(mem_wr), 32'd0);
        check("rs_a", mem_a, 32'd0);
        check("rs_dout", 32'(mem_dout), 32'd0);
        check("rs_if_data", if_data, 32'd0);
        step();
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            check("rs_no_done", 32'(st_done), 32'd0);
        end
        check("rs_ram0", 32'(ram_rd(32'hA00)), 32'h88);
        check("rs_ram1", 32'(ram_rd(32'hA01)), 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
